ps2_tx_sequencer: RTL and testbench

Controller between the key-event FIFO, the PS/2 byte transmitter and the host-command receiver in the keyboard emulator. Pops key events and expands each one into scan-code bytes: optional E0 prefix, optional F0 break prefix, then the code. Answers host commands (ED set-LEDs, FF reset, EE echo) with priority over key traffic. Owns the num/caps/scroll lock state.

---
 rtl/ps2_tx_sequencer_if.sv | 23 ++
 rtl/ps2_tx_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_tx_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_sequencer_if.sv
// Handshake bundle between the scan-code sequencer and its key-event FIFO,
// PS/2 byte transmitter and host-command receiver.
interface ps2_tx_sequencer_if;
    logic       fifo_empty;
    logic [9:0] fifo_data;
    logic       fifo_rd;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_ready, tx_done, rx_valid, rx_data,
        output fifo_rd, tx_valid, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_ready, tx_done, rx_valid, rx_data,
        input  fifo_rd, tx_valid, tx_data
    );
endinterface

// File: rtl/ps2_tx_sequencer.sv
// Expands key events into PS/2 scan-code bytes and answers host commands (ED/FF/EE).
// Optional macro SEQ_RESEND_EN: host FE resends the last transmitted byte.
module ps2_tx_sequencer #(
    parameter int GAP_CYCLES = 2500,
    parameter int GAP_W      = 12
) (
    input  logic                      clock_50,
    input  logic                      reset,
    ps2_tx_sequencer_if.master        bus,
    output logic                      num_lock,
    output logic                      caps_lock,
    output logic                      scroll_lock,
    output logic                      busy
);
    typedef enum logic [2:0] {
        IDLE, POP, LOAD, SEND, WAIT_DONE, GAP, WAIT_ARG
    } state_t;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_ED = 8'hED;
    localparam logic [7:0] B_FF = 8'hFF;
`ifdef SEQ_RESEND_EN
    localparam logic [7:0] B_FE = 8'hFE;
`endif
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t          state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            cmd_pend_q, cmd_pend_d;
    logic [2:0][7:0] seq_q, seq_d;       // seq_q[0] is the next byte to send
    logic [1:0]      seq_n_q, seq_n_d;
    logic            arg_ctx_q, arg_ctx_d;
    logic            clr_led_q, clr_led_d;
    logic [2:0]      led_q, led_d;       // {caps, num, scroll}
    logic [7:0]      tx_data_q, tx_data_d;

    logic            pop_c;
    logic            take_cmd;
    logic            tx_acc;
    logic [2:0][7:0] rsp_seq;
    logic [1:0]      rsp_n;
    logic            rsp_arg;
    logic            rsp_clr;

`ifdef SEQ_RESEND_EN
    logic [7:0]      last_q, last_d;
`endif

    assign tx_acc = (state_q == SEND) && bus.tx_ready;

    // Response byte list for the pending host command when serviced from IDLE.
    always_comb begin
        rsp_seq = {8'h00, 8'h00, B_FA};
        rsp_n   = 2'd1;
        rsp_arg = 1'b0;
        rsp_clr = 1'b0;
        case (cmd_q)
            B_ED: rsp_arg = 1'b1;
            B_FF: begin
                rsp_seq = {8'h00, B_AA, B_FA};
                rsp_n   = 2'd2;
                rsp_clr = 1'b1;
            end
            B_EE: rsp_seq[0] = B_EE;
`ifdef SEQ_RESEND_EN
            B_FE: rsp_seq[0] = last_q;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        cmd_d      = cmd_q;
        cmd_pend_d = cmd_pend_q;
        seq_d      = seq_q;
        seq_n_d    = seq_n_q;
        arg_ctx_d  = arg_ctx_q;
        clr_led_d  = clr_led_q;
        led_d      = led_q;
        tx_data_d  = tx_data_q;
        pop_c      = 1'b0;
        take_cmd   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_pend_q) begin
                    take_cmd  = 1'b1;
                    seq_d     = rsp_seq;
                    seq_n_d   = rsp_n;
                    arg_ctx_d = rsp_arg;
                    clr_led_d = rsp_clr;
                    state_d   = LOAD;
                end else if (!bus.rx_valid && !bus.fifo_empty) begin
                    // A host byte landing this cycle holds off the pop so the command goes first.
                    pop_c   = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                case (bus.fifo_data[9:8])
                    2'b11:   begin seq_d = {bus.fifo_data[7:0], B_F0, B_E0}; seq_n_d = 2'd3; end
                    2'b10:   begin seq_d = {8'h00, bus.fifo_data[7:0], B_E0}; seq_n_d = 2'd2; end
                    2'b01:   begin seq_d = {8'h00, bus.fifo_data[7:0], B_F0}; seq_n_d = 2'd2; end
                    default: begin seq_d = {8'h00, 8'h00, bus.fifo_data[7:0]}; seq_n_d = 2'd1; end
                endcase
                arg_ctx_d = 1'b0;
                clr_led_d = 1'b0;
                state_d   = LOAD;
            end
            LOAD: begin
                tx_data_d = seq_q[0];
                seq_d     = {8'h00, seq_q[2], seq_q[1]};
                seq_n_d   = seq_n_q - 2'd1;
                state_d   = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    state_d = WAIT_DONE;
                    if (clr_led_q && (seq_n_q == 2'd0)) begin
                        led_d     = 3'b000;
                        clr_led_d = 1'b0;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (seq_n_q != 2'd0)  state_d = LOAD;
                    else if (arg_ctx_q)   state_d = WAIT_ARG;
                    else                  state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            WAIT_ARG: begin
                if (cmd_pend_q) begin
                    take_cmd = 1'b1;
                    seq_d    = {8'h00, 8'h00, B_FA};
                    seq_n_d  = 2'd1;
                    if (cmd_q == B_ED) begin
                        arg_ctx_d = 1'b1;
                    end else begin
                        led_d     = cmd_q[2:0];
                        arg_ctx_d = 1'b0;
                    end
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_cmd) cmd_pend_d = 1'b0;
        // Fresh host byte always wins over the clear: last received byte stays pending.
        if (bus.rx_valid) begin
            cmd_d      = bus.rx_data;
            cmd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            cmd_q      <= '0;
            cmd_pend_q <= 1'b0;
            seq_q      <= '0;
            seq_n_q    <= '0;
            arg_ctx_q  <= 1'b0;
            clr_led_q  <= 1'b0;
            led_q      <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            cmd_q      <= cmd_d;
            cmd_pend_q <= cmd_pend_d;
            seq_q      <= seq_d;
            seq_n_q    <= seq_n_d;
            arg_ctx_q  <= arg_ctx_d;
            clr_led_q  <= clr_led_d;
            led_q      <= led_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef SEQ_RESEND_EN
    always_comb begin
        last_d = last_q;
        if (tx_acc) last_d = tx_data_q;
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) last_q <= '0;
        else       last_q <= last_d;
    end
`else
    logic unused_acc;
    assign unused_acc = tx_acc;
`endif

    // Pop strobe is masked during reset so a non-empty FIFO is not drained while held.
    assign bus.fifo_rd  = pop_c && !reset;
    assign bus.tx_valid = (state_q == SEND);
    assign bus.tx_data  = tx_data_q;
    assign scroll_lock  = led_q[0];
    assign num_lock     = led_q[1];
    assign caps_lock    = led_q[2];
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_tx_sequencer.sv
// Self-checking bench for ps2_tx_sequencer: scoreboarded byte stream plus LED/handshake checks.
`timescale 1ns/1ps
module tb_ps2_tx_sequencer;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst;
    logic num_lock, caps_lock, scroll_lock, busy;

    ps2_tx_sequencer_if ifc();

    ps2_tx_sequencer #(.GAP_CYCLES(GAP), .GAP_W(12)) dut (
        .clock_50   (clk),
        .reset      (rst),
        .bus        (ifc),
        .num_lock   (num_lock),
        .caps_lock  (caps_lock),
        .scroll_lock(scroll_lock),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         rd_cnt   = 0;
    int         done_cyc = -1000;
    bit         resp_en  = 1'b1;
    logic [7:0] exp_q[$];
    logic [9:0] evq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Key-event FIFO model: data appears the cycle after the pop strobe.
    initial begin
        logic [9:0] ev;
        ifc.fifo_empty = 1'b1;
        ifc.fifo_data  = '0;
        forever begin
            @(negedge clk); #1;
            ifc.fifo_empty = (evq.size() == 0);
            #1;
            if (ifc.fifo_rd === 1'b1 && evq.size() > 0) begin
                ev = evq.pop_front();
                rd_cnt++;
                @(posedge clk); #1;
                ifc.fifo_data = ev;
            end
        end
    end

    // Transmitter model: random accept delay, then a tx_done pulse; scoreboard on accept.
    initial begin
        int         d;
        logic [7:0] e;
        ifc.tx_ready = 1'b0;
        ifc.tx_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && ifc.tx_valid === 1'b1) begin
                checks++;
                if (cyc - done_cyc < GAP + 1) begin
                    failures++;
                    $display("FAIL gap cycles_since_done=%0d required>=%0d", cyc - done_cyc, GAP + 1);
                end
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                ifc.tx_ready = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_byte got=%02h required=none", ifc.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ifc.tx_data !== e) begin
                        failures++;
                        $display("FAIL sb_byte got=%02h required=%02h", ifc.tx_data, e);
                    end
                end
                @(negedge clk);
                ifc.tx_ready = 1'b0;
                d = $urandom_range(2, 5);
                repeat (d) @(negedge clk);
                ifc.tx_done = 1'b1;
                @(negedge clk);
                ifc.tx_done = 1'b0;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_host(input logic [7:0] b);
        @(negedge clk);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic wait_quiet(output bit ok);
        int calm = 0;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && evq.size() == 0) calm++;
            else calm = 0;
            if (calm >= 4) begin ok = 1'b1; break; end
        end
    endtask

    // Drain expected bytes, then allow the gap to finish (lands in WAIT_ARG after an ED).
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (2 * GAP + 20) @(negedge clk);
    endtask

    task automatic wait_tx_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ifc.tx_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifc.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b required=0", ifc.tx_valid); end
        checks++; if (ifc.fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b required=0", ifc.fifo_rd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b000) begin
            failures++; $display("FAIL reset_leds got=%b required=000", {caps_lock, num_lock, scroll_lock});
        end
        rst = 1'b0;
    endtask

    task automatic test_resend_first;
        bit ok;
`ifdef SEQ_RESEND_EN
        exp_q.push_back(8'h00);
`else
        exp_q.push_back(8'hFA);
`endif
        send_host(8'hFE);
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL resend_first_timeout got=busy required=idle"); end
    endtask

    task automatic test_latency_break;
        bit ok;
        int n = 0;
        int rd0 = rd_cnt;
        exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(8'h75);
        @(negedge clk);
        evq.push_back({1'b1, 1'b1, 8'h75});
        #2;
        while (ifc.tx_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL latency got=%0d required=3", n); end
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL break_timeout got=busy required=idle"); end
        checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL break_pops got=%0d required=1", rd_cnt - rd0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int rd0 = rd_cnt;
        logic [9:0] evs [3] = '{10'h01C, 10'h11C, 10'h26B};
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h1C);
        exp_q.push_back(8'hE0); exp_q.push_back(8'h6B);
        @(negedge clk);
        for (int i = 0; i < 3; i++) evq.push_back(evs[i]);
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=busy required=idle"); end
        checks++; if (rd_cnt - rd0 != 3) begin failures++; $display("FAIL b2b_pops got=%0d required=3", rd_cnt - rd0); end
    endtask

    task automatic test_led;
        bit ok;
        exp_q.push_back(8'hFA);
        send_host(8'hED);
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL led_ack_timeout got=pending required=drained"); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL led_wait_arg_busy got=%b required=1", busy); end
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b000) begin
            failures++; $display("FAIL led_before_arg got=%b required=000", {caps_lock, num_lock, scroll_lock});
        end
        exp_q.push_back(8'hFA);
        send_host(8'h05);
        @(negedge clk);
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b101) begin
            failures++; $display("FAIL led_after_arg got=%b required=101", {caps_lock, num_lock, scroll_lock});
        end
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL led_final_timeout got=busy required=idle"); end
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        resp_en = 1'b0;
        @(negedge clk);
        evq.push_back(10'h016);
        evq.push_back(10'h01E);
        wait_tx_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_send_timeout got=no_tx_valid required=tx_valid"); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (ifc.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid got=%b required=0", ifc.tx_valid); end
        checks++; if (ifc.fifo_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_fifo_rd got=%b required=0", ifc.fifo_rd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_leds got=%b required=000", {caps_lock, num_lock, scroll_lock});
        end
        exp_q.push_back(8'h1E);
        resp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_resume_timeout got=busy required=idle"); end
    endtask

    task automatic test_ff_mid_event;
        bit ok;
        int rd0;
        exp_q.push_back(8'hFA);
        send_host(8'hED);
        wait_drain(ok);
        exp_q.push_back(8'hFA);
        send_host(8'hED);
        wait_drain(ok);
        exp_q.push_back(8'hFA);
        send_host(8'h07);
        wait_quiet(ok);
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b111) begin
            failures++; $display("FAIL ed_reissue_leds got=%b required=111", {caps_lock, num_lock, scroll_lock});
        end
        rd0 = rd_cnt;
        exp_q.push_back(8'h1C); exp_q.push_back(8'hFA); exp_q.push_back(8'hAA);
        @(negedge clk);
        evq.push_back(10'h01C);
        wait_tx_valid(ok);
        send_host(8'hFF);
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ff_timeout got=busy required=idle"); end
        checks++; if ({caps_lock, num_lock, scroll_lock} !== 3'b000) begin
            failures++; $display("FAIL ff_leds got=%b required=000", {caps_lock, num_lock, scroll_lock});
        end
        checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL ff_pops got=%0d required=1", rd_cnt - rd0); end
    endtask

    task automatic test_priority;
        bit ok = 1'b0;
        int rd0 = rd_cnt;
        exp_q.push_back(8'hEE); exp_q.push_back(8'h1C);
        @(negedge clk);
        evq.push_back(10'h01C);
        ifc.rx_data  = 8'hEE;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() <= 1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL prio_timeout got=no_echo required=echo"); end
        checks++; if (rd_cnt != rd0) begin failures++; $display("FAIL prio_pop_before_echo got=%0d required=%0d", rd_cnt, rd0); end
        wait_quiet(ok);
        checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL prio_pops got=%0d required=1", rd_cnt - rd0); end
    endtask

    task automatic test_cmd_misc;
        bit ok;
`ifdef SEQ_RESEND_EN
        exp_q.push_back(8'h1C);
`else
        exp_q.push_back(8'hFA);
`endif
        send_host(8'hFE);
        wait_quiet(ok);
        exp_q.push_back(8'hFA);
        send_host(8'hF4);
        wait_quiet(ok);
        checks++; if (!ok) begin failures++; $display("FAIL misc_timeout got=busy required=idle"); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL misc_leftover got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = '0;
        test_reset();
        test_resend_first();
        test_latency_break();
        test_back_to_back();
        test_led();
        test_reset_mid_send();
        test_ff_mid_event();
        test_priority();
        test_cmd_misc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
